// File: rtl/reg_access_sequencer_if.sv
// -----------------------------------------------------------------------------
// reg_access_sequencer_if
// Groups the decode-stage, register-file and ALU signals seen by the register
// access sequencer. clk/rst are kept outside the bundle.
//
// Signal groups:
//   decode : instr_valid/instr_ready, instr_rs1/rs2/rd (8b, [4:0] used), instr_wb
//   regfile: A1/A2/A3, WriteData, Flag_input, regReadEnable, regWriteEnable,
//            RD1/RD2
//   ALU    : op_valid/op_ready, op_a/op_b, res_valid/res_ready, res_data,
//            res_flags
//   status : busy, err_flag_dst, retired
//
// Modports:
//   master : the sequencer itself
//   slave  : the surrounding decode stage, register file and ALU
// -----------------------------------------------------------------------------
interface reg_access_sequencer_if;
   // decode stage
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  instr_rs1;
   logic [7:0]  instr_rs2;
   logic [7:0]  instr_rd;
   logic        instr_wb;
   // register file
   logic [7:0]  A1;
   logic [7:0]  A2;
   logic [7:0]  A3;
   logic [7:0]  WriteData;
   logic [6:0]  Flag_input;
   logic        regReadEnable;
   logic        regWriteEnable;
   logic [7:0]  RD1;
   logic [7:0]  RD2;
   // ALU
   logic        op_valid;
   logic        op_ready;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_data;
   logic [6:0]  res_flags;
   // status
   logic        busy;
   logic        err_flag_dst;
   logic [15:0] retired;

   modport master (
      input  instr_valid, instr_rs1, instr_rs2, instr_rd, instr_wb,
      output instr_ready,
      output A1, A2, A3, WriteData, Flag_input, regReadEnable, regWriteEnable,
      input  RD1, RD2,
      output op_valid, op_a, op_b,
      input  op_ready,
      input  res_valid, res_data, res_flags,
      output res_ready,
      output busy, err_flag_dst, retired
   );

   modport slave (
      output instr_valid, instr_rs1, instr_rs2, instr_rd, instr_wb,
      input  instr_ready,
      input  A1, A2, A3, WriteData, Flag_input, regReadEnable, regWriteEnable,
      output RD1, RD2,
      input  op_valid, op_a, op_b,
      output op_ready,
      output res_valid, res_data, res_flags,
      input  res_ready,
      input  busy, err_flag_dst, retired
   );
endinterface

// File: rtl/reg_access_sequencer.sv
// -----------------------------------------------------------------------------
// reg_access_sequencer
// Master-side controller between decode and the ALU/register-file pair. It
// accepts one register instruction at a time, reads both operands from the
// register file, hands them to the ALU over valid/ready, collects the result
// and flags, and writes them back (unless the op discards its result).
//
// Parameters:
//   READ_WAIT : cycles regReadEnable is held before RD1/RD2 are sampled (1..15)
//   FLAG_REG  : register index the register file overwrites with Flag_input;
//               a writeback aimed at it is suppressed and flagged
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : reg_access_sequencer_if.master (decode, regfile, ALU, status)
//
// Flow: IDLE -> READ (READ_WAIT cycles) -> ISSUE -> WAIT_RES -> WRITE -> IDLE,
// with WAIT_RES retiring straight to IDLE when no writeback is wanted.
// -----------------------------------------------------------------------------
module reg_access_sequencer #(
   parameter int READ_WAIT = 1,
   parameter int FLAG_REG  = 3
) (
   input logic                   clk,
   input logic                   rst,
   reg_access_sequencer_if.master bus
);

   localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT);
   localparam logic [4:0] FLAG_IDX  = 5'(FLAG_REG);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      ISSUE,
      WAIT_RES,
      WRITE
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // latched instruction fields; upper address bits are dropped on entry
   logic [4:0]  rs1_q;
   logic [4:0]  rs2_q;
   logic [4:0]  rd_q;
   logic        wb_q;
   logic [3:0]  wait_cnt;

   logic [7:0]  op_a_q;
   logic [7:0]  op_b_q;
   logic [7:0]  res_data_q;
   logic [6:0]  res_flags_q;
   logic        err_q;
   logic [15:0] retired_cnt;

   // per-cycle control decoded from the state
   logic        accept;
   logic        capture;
   logic        res_take;
   logic        retire;
   logic        flag_dst_hit;
   logic        ready_c;
   logic        rd_en_c;
   logic        op_valid_c;
   logic        res_ready_c;
   logic        wr_en_c;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and control decode
   always_comb begin
      state_nxt    = state;
      accept       = 1'b0;
      capture      = 1'b0;
      res_take     = 1'b0;
      retire       = 1'b0;
      flag_dst_hit = 1'b0;
      ready_c      = 1'b0;
      rd_en_c      = 1'b0;
      op_valid_c   = 1'b0;
      res_ready_c  = 1'b0;
      wr_en_c      = 1'b0;

      case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.instr_valid) begin
               accept    = 1'b1;
               state_nxt = READ;
            end
         end
         READ: begin
            rd_en_c = 1'b1;
            // <= 1 rather than == 1 so a stray zero count cannot lock up READ
            if (wait_cnt <= 4'd1) begin
               capture   = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            op_valid_c = 1'b1;
            if (bus.op_ready) begin
               state_nxt = WAIT_RES;
            end
         end
         WAIT_RES: begin
            res_ready_c = 1'b1;
            if (bus.res_valid) begin
               res_take = 1'b1;
               if (wb_q && (rd_q != FLAG_IDX)) begin
                  state_nxt = WRITE;
               end else begin
                  // compare-type op, or a writeback the flag register would
                  // clobber anyway: retire without touching the register file
                  state_nxt    = IDLE;
                  retire       = 1'b1;
                  flag_dst_hit = wb_q;
               end
            end
         end
         WRITE: begin
            wr_en_c   = 1'b1;
            state_nxt = IDLE;
            retire    = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // datapath latches, counters and status
   always_ff @(posedge clk) begin
      if (rst) begin
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         wb_q        <= 1'b0;
         wait_cnt    <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         res_data_q  <= '0;
         res_flags_q <= '0;
         err_q       <= 1'b0;
         retired_cnt <= '0;
      end else begin
         if (accept) begin
            rs1_q    <= bus.instr_rs1[4:0];
            rs2_q    <= bus.instr_rs2[4:0];
            rd_q     <= bus.instr_rd[4:0];
            wb_q     <= bus.instr_wb;
            wait_cnt <= WAIT_INIT;
         end else if (state == READ) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         if (capture) begin
            op_a_q <= bus.RD1;
            op_b_q <= bus.RD2;
         end

         if (res_take) begin
            res_data_q  <= bus.res_data;
            res_flags_q <= bus.res_flags;
         end

         err_q <= flag_dst_hit;

         // 16-bit add wraps FFFF -> 0 by itself
         if (retire) begin
            retired_cnt <= retired_cnt + 16'd1;
         end
      end
   end

   // addresses and write data simply reflect the latches, so they hold their
   // last value whenever the corresponding enable is low
   assign bus.instr_ready    = ready_c;
   assign bus.A1             = {3'b000, rs1_q};
   assign bus.A2             = {3'b000, rs2_q};
   assign bus.A3             = {3'b000, rd_q};
   assign bus.WriteData      = res_data_q;
   assign bus.Flag_input     = res_flags_q;
   assign bus.regReadEnable  = rd_en_c;
   assign bus.regWriteEnable = wr_en_c;
   assign bus.op_valid       = op_valid_c;
   assign bus.op_a           = op_a_q;
   assign bus.op_b           = op_b_q;
   assign bus.res_ready      = res_ready_c;
   assign bus.busy           = (state != IDLE);
   assign bus.err_flag_dst   = err_q;
   assign bus.retired        = retired_cnt;

endmodule

// File: doc/reg_access_sequencer.md
Name: reg_access_sequencer

Overview:
- Master-side controller for the register file. It drives the register file's read addresses A1/A2, write address A3, WriteData, Flag_input, regReadEnable and regWriteEnable.
- Accepts one decoded register instruction at a time, fetches both operands, and hands them to the ALU over a valid/ready handshake.
- Collects the ALU result and flags, then writes them back.
- Sits between the decode stage and the ALU/register file pair.

Parameters:
- READ_WAIT, 1: cycles regReadEnable is held before RD1/RD2 are sampled. Range 1..15; covers the register file's read delay.
- FLAG_REG, 3: register index that the register file overwrites with Flag_input on every write.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  decode stage presents an instruction.
- instr_ready  out  1  sequencer accepts an instruction this cycle.
- instr_rs1  in  8  source 1 register address; only [4:0] significant.
- instr_rs2  in  8  source 2 register address; only [4:0] significant.
- instr_rd  in  8  destination register address; only [4:0] significant.
- instr_wb  in  1  1 = write the result back, 0 = discard it (compare-type ops).
- A1  out  8  register file read address 1.
- A2  out  8  register file read address 2.
- A3  out  8  register file write address.
- WriteData  out  8  write data to the register file.
- Flag_input  out  7  flags to the register file.
- regReadEnable  out  1  register file read enable.
- regWriteEnable  out  1  register file write enable.
- RD1  in  8  register file read data 1.
- RD2  in  8  register file read data 2.
- op_valid  out  1  operands valid to the ALU.
- op_ready  in  1  ALU takes the operands.
- op_a  out  8  operand A.
- op_b  out  8  operand B.
- res_valid  in  1  ALU result valid.
- res_ready  out  1  sequencer takes the result.
- res_data  in  8  ALU result.
- res_flags  in  7  ALU flags.
- busy  out  1  high in any state other than IDLE.
- err_flag_dst  out  1  one-cycle pulse when a writeback is suppressed because rd targets FLAG_REG.
- retired  out  16  count of completed instructions; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset: rst sampled at a rising edge forces the following, regardless of state, including mid-write:
  - state = IDLE;
  - all outputs 0, except instr_ready = 1;
  - internal rs1/rs2/rd/wb latches and the wait counter cleared.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch rs1, rs2, rd and wb, load the wait counter with READ_WAIT, and go to READ.
- READ:
  - regReadEnable = 1; A1 = {3'b0, rs1[4:0]}; A2 = {3'b0, rs2[4:0]}.
  - The counter decrements each cycle.
  - In the cycle the counter reaches 1, RD1 is captured into op_a and RD2 into op_b, and the state goes to ISSUE.
  - READ therefore lasts exactly READ_WAIT cycles.
- ISSUE:
  - op_valid = 1; op_a and op_b are held stable while op_valid is high.
  - On op_ready, go to WAIT_RES; op_valid drops the next cycle.
- WAIT_RES:
  - res_ready = 1.
  - On res_valid, latch res_data and res_flags.
  - If wb = 1 and rd[4:0] != FLAG_REG, go to WRITE.
  - Otherwise retire directly to IDLE. If wb = 1 and rd[4:0] == FLAG_REG, also pulse err_flag_dst for one cycle.
- WRITE (one cycle):
  - regWriteEnable = 1; A3 = {3'b0, rd[4:0]}; WriteData = latched result; Flag_input = latched flags.
  - Next state is IDLE.
- Retirement: retired increments by 1 on every exit to IDLE from WRITE or WAIT_RES.
- Idle values: regReadEnable = 0 outside READ and regWriteEnable = 0 outside WRITE. A1, A2, A3 and WriteData hold their last value; they are don't-care when the enables are 0.
- No overlap: a new instruction is not accepted until the cycle after WRITE/retire. Minimum issue interval = READ_WAIT + 3 cycles with a zero-wait ALU.
- Read-after-write hazard: none is possible because writeback completes before the next READ.
- Upper address bits: bits [7:5] of instr_rs1, instr_rs2 and instr_rd are ignored; A1, A2 and A3 always carry 0 in bits [7:5].
- Ignored inputs:
  - instr_valid while busy is ignored; no latching.
  - res_valid outside WAIT_RES is ignored.
  - op_ready outside ISSUE is ignored.

Test Plan:
- Basic op, READ_WAIT = 1: preload r5 = 8'h12, r6 = 8'h34. Issue rs1 = 5, rs2 = 6, rd = 7, wb = 1; ALU returns 8'h46 with flags 7'h01. Required response:
  - op_a = 8'h12, op_b = 8'h34;
  - one regWriteEnable cycle with A3 = 8'h07, WriteData = 8'h46, Flag_input = 7'h01;
  - retired = 1.
- Wait-state and stall test: READ_WAIT = 4 and op_ready delayed 3 cycles. Required response:
  - regReadEnable high for exactly 4 cycles;
  - op_valid high for exactly 4 cycles with op_a/op_b stable;
  - instr_ready = 0 throughout.
- No writeback: wb = 0. Required response: regWriteEnable never asserts; retired increments; instr_ready returns the cycle after res_valid.
- Flag-register destination: wb = 1, rd = 8'h03. Required response: no write; err_flag_dst pulses exactly 1 cycle; retired increments.
- Reset mid-op: assert rst during ISSUE and separately during WRITE. Required response: next cycle state = IDLE, op_valid = 0, regWriteEnable = 0, retired = 0, instr_ready = 1.
- Address masking and wrap: rs1 = 8'hE2 gives A1 = 8'h02. With retired preset to 16'hFFFF via 65535 ops, or forced, the next retire gives 16'h0000.
